// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame clocked by the device, ACK check.
// Optional watchdog compiled in with `define PS2_TX_TIMEOUT_EN. INHIBIT_CYCLES must be at least 2.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_data_oe,
  output logic       o_busy,
  output logic       o_tx_done,
  output logic       o_tx_error
);
  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_RTS, S_SHIFT, S_ACK} state_t;

  state_t           r_state, w_state_next;
  logic [INH_W-1:0] r_inh_cnt, w_inh_cnt_next;
  logic [3:0]       r_bit_cnt, w_bit_cnt_next;
  logic [9:0]       r_shift, w_shift_next;
  logic             r_clk_oe, w_clk_oe_next;
  logic             r_data_oe, w_data_oe_next;
  logic             r_done, w_done_next;
  logic             r_error, w_error_next;
  logic             r_clk_s1, r_clk_s2, r_clk_prev;
  logic             r_data_s1, r_data_s2;
  logic             w_fe, w_accept, w_timeout, w_wd_active;

  assign w_fe        = r_clk_prev & ~r_clk_s2;
  assign w_wd_active = (r_state == S_RTS) || (r_state == S_SHIFT) || (r_state == S_ACK);
  // Ready stays low during the done/error pulse so a new accept never overlaps it.
  assign o_tx_ready  = (r_state == S_IDLE) && !r_done && !r_error;
  assign w_accept    = i_tx_valid && o_tx_ready;
  assign o_busy      = (r_state != S_IDLE);
  assign o_ps2_clk_oe  = r_clk_oe;
  assign o_ps2_data_oe = r_data_oe;
  assign o_tx_done   = r_done;
  assign o_tx_error  = r_error;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] r_wd_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !w_wd_active) begin
      r_wd_cnt <= '0;
    end else if (!w_timeout) begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end
  end

  assign w_timeout = w_wd_active && (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
  // No watchdog: a stalled device holds the transfer until reset.
  assign w_timeout = w_wd_active && (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_inh_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_data_s1  <= 1'b1;
      r_data_s2  <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_inh_cnt  <= w_inh_cnt_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_shift    <= w_shift_next;
      r_clk_oe   <= w_clk_oe_next;
      r_data_oe  <= w_data_oe_next;
      r_done     <= w_done_next;
      r_error    <= w_error_next;
      r_clk_s1   <= i_ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_data_s1  <= i_ps2_data;
      r_data_s2  <= r_data_s1;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_inh_cnt_next = r_inh_cnt;
    w_bit_cnt_next = r_bit_cnt;
    w_shift_next   = r_shift;
    w_clk_oe_next  = r_clk_oe;
    w_data_oe_next = r_data_oe;
    w_done_next    = 1'b0;
    w_error_next   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_clk_oe_next  = 1'b0;
        w_data_oe_next = 1'b0;
        if (w_accept) begin
          w_shift_next   = {1'b1, ~^i_tx_data, i_tx_data};
          w_inh_cnt_next = '0;
          w_bit_cnt_next = '0;
          w_clk_oe_next  = 1'b1;
          w_state_next   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        w_inh_cnt_next = r_inh_cnt + INH_W'(1);
        // Registered one cycle early so the start bit appears in the last inhibit cycle.
        if (r_inh_cnt >= INH_W'(INHIBIT_CYCLES - 2)) w_data_oe_next = 1'b1;
        if (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
          w_inh_cnt_next = '0;
          w_clk_oe_next  = 1'b0;
          w_state_next   = S_RTS;
        end
      end
      S_RTS: begin
        w_data_oe_next = 1'b1;
        if (w_fe) begin
          w_data_oe_next = ~r_shift[0];
          w_shift_next   = {1'b0, r_shift[9:1]};
          w_bit_cnt_next = 4'd1;
          w_state_next   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_fe) begin
          w_data_oe_next = ~r_shift[0];
          w_shift_next   = {1'b0, r_shift[9:1]};
          w_bit_cnt_next = r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd9) w_state_next = S_ACK;
        end
      end
      S_ACK: begin
        if (w_fe) begin
          w_done_next    = ~r_data_s2;
          w_error_next   = r_data_s2;
          w_clk_oe_next  = 1'b0;
          w_data_oe_next = 1'b0;
          w_state_next   = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    if (w_timeout) begin
      w_done_next    = 1'b0;
      w_error_next   = 1'b1;
      w_clk_oe_next  = 1'b0;
      w_data_oe_next = 1'b0;
      w_state_next   = S_IDLE;
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: open-drain device model clocks frames and answers ACK/NACK.
// Watchdog scenario is exercised only when PS2_TX_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INH = 60;
  localparam int TO  = 1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_error;
  logic       dev_clk = 1'b1, dev_data = 1'b1;
  logic       ps2_clk_line, ps2_data_line;

  always #5 clk = ~clk;

  assign ps2_clk_line  = dev_clk  & ~ps2_clk_oe;
  assign ps2_data_line = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(tx_data), .i_tx_valid(tx_valid),
    .o_tx_ready(tx_ready), .i_ps2_clk(ps2_clk_line), .i_ps2_data(ps2_data_line),
    .o_ps2_clk_oe(ps2_clk_oe), .o_ps2_data_oe(ps2_data_oe), .o_busy(busy),
    .o_tx_done(tx_done), .o_tx_error(tx_error)
  );

  int errors = 0, checks = 0;
  int cyc = 0, done_cnt = 0, err_cnt = 0;
  int hp = 10, rel_cyc = 0, fe1_lat, ack_lat;
  logic [10:0] dev_bits;
  logic ready_at_pulse, ready_after;

  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (tx_done)  done_cnt++;
    if (tx_error) err_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  // Reference frame as the device sees it: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      ones += int'(b[i]);
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic start_tx(input logic [7:0] b, input string tag);
    int guard, n_oe, n_both;
    guard = 0;
    while (tx_ready !== 1'b1 && guard < 5000) begin @(negedge clk); guard++; end
    checks++;
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL %s_ready: tx_ready=%b required 1", tag, tx_ready); end
    tx_data = b; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    checks++;
    if ({busy, ps2_clk_oe, tx_ready} !== 3'b110) begin
      errors++; $display("FAIL %s_accept: busy/clk_oe/ready=%b required 110", tag, {busy, ps2_clk_oe, tx_ready});
    end
    n_oe = 0; n_both = 0; guard = 0;
    while (ps2_clk_oe === 1'b1 && guard < INH + 20) begin
      n_oe++;
      if (ps2_data_oe === 1'b1) n_both++;
      @(negedge clk); guard++;
    end
    rel_cyc = cyc;
    checks++;
    if (n_oe !== INH) begin errors++; $display("FAIL %s_inhibit_len: %0d cycles required %0d", tag, n_oe, INH); end
    checks++;
    if (n_both !== 1) begin errors++; $display("FAIL %s_start_overlap: %0d cycles required 1", tag, n_both); end
    checks++;
    if (ps2_data_oe !== 1'b1) begin errors++; $display("FAIL %s_rts_data: data_oe=%b required 1", tag, ps2_data_oe); end
  endtask

  // Device: nclk clock pulses; samples start before fe1 and bits on rising edges 1..10.
  task automatic dev_run(input int nclk, input logic ack_bit);
    logic prev_oe;
    fe1_lat = -1; ack_lat = -1; dev_bits = '1;
    ready_at_pulse = 1'bx; ready_after = 1'bx;
    repeat ($urandom_range(2, 12)) @(negedge clk);
    dev_bits[0] = ps2_data_line;
    for (int k = 1; k <= nclk; k++) begin
      prev_oe = ps2_data_oe;
      dev_clk = 1'b0;
      for (int j = 1; j <= hp; j++) begin
        @(negedge clk);
        if (k == 1 && fe1_lat < 0 && ps2_data_oe !== prev_oe) fe1_lat = j;
        if (k == 11 && ack_lat >= 0 && j == ack_lat + 1) ready_after = tx_ready;
        if (k == 11 && ack_lat < 0 && (tx_done || tx_error)) begin ack_lat = j; ready_at_pulse = tx_ready; end
      end
      if (k <= 10) dev_bits[k] = ps2_data_line;
      dev_clk = 1'b1;
      repeat (hp / 2) @(negedge clk);
      if (k == 10) dev_data = ack_bit;
      repeat (hp - hp / 2) @(negedge clk);
      if (k == 11) dev_data = 1'b1;
    end
  endtask

  task automatic test_frame(input logic [7:0] b, input logic ack_bit, input string tag);
    logic [10:0] exp;
    int d0, e0;
    exp = frame_of(b); d0 = done_cnt; e0 = err_cnt;
    hp = $urandom_range(8, 16);
    start_tx(b, tag);
    dev_run(11, ack_bit);
    checks++;
    if (dev_bits !== exp) begin errors++; $display("FAIL %s_bits: got %b required %b", tag, dev_bits, exp); end
    if (b[0]) begin
      checks++;
      if (fe1_lat !== 3) begin errors++; $display("FAIL %s_fe_latency: %0d cycles required 3", tag, fe1_lat); end
    end
    checks++;
    if (ack_lat !== 3) begin errors++; $display("FAIL %s_ack_latency: %0d cycles required 3", tag, ack_lat); end
    checks++;
    if ({ready_at_pulse, ready_after} !== 2'b01) begin
      errors++; $display("FAIL %s_ready_after_pulse: %b required 01", tag, {ready_at_pulse, ready_after});
    end
    checks++;
    if (done_cnt - d0 !== int'(!ack_bit) || err_cnt - e0 !== int'(ack_bit)) begin
      errors++; $display("FAIL %s_result: done=%0d err=%0d required done=%0d err=%0d",
                         tag, done_cnt - d0, err_cnt - e0, int'(!ack_bit), int'(ack_bit));
    end
    checks++;
    if ({busy, tx_ready, ps2_clk_oe, ps2_data_oe} !== 4'b0100) begin
      errors++; $display("FAIL %s_idle: busy/ready/clk_oe/data_oe=%b required 0100", tag, {busy, tx_ready, ps2_clk_oe, ps2_data_oe});
    end
    $display("tx %s byte=%02h ack=%0d bits=%b done=%0d err=%0d", tag, b, ack_bit, dev_bits, done_cnt - d0, err_cnt - e0);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_ready, busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_error} !== 6'b100000) begin
      errors++; $display("FAIL reset_state: ready/busy/clk_oe/data_oe/done/err=%b required 100000",
                         {tx_ready, busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_error});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({tx_ready, busy} !== 2'b10) begin errors++; $display("FAIL reset_release: ready/busy=%b required 10", {tx_ready, busy}); end
    $display("tx reset ready=%b busy=%b", tx_ready, busy);
  endtask

  task automatic test_send_ed();
    test_frame(8'hED, 1'b0, "send_ed");
  endtask

  task automatic test_nack();
    test_frame(8'hF4, 1'b1, "nack_f4");
  endtask

  task automatic test_ignore_valid();
    int d0;
    d0 = done_cnt; hp = 10;
    start_tx(8'hED, "ignore");
    fork
      dev_run(11, 1'b0);
      begin
        repeat (80) @(negedge clk);
        tx_data = 8'h00; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    checks++;
    if (dev_bits !== frame_of(8'hED)) begin errors++; $display("FAIL ignore_bits: got %b required %b", dev_bits, frame_of(8'hED)); end
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL ignore_done: %0d pulses required 1", done_cnt - d0); end
    repeat (INH + 20) @(negedge clk);
    checks++;
    if ({busy, ps2_clk_oe} !== 2'b00) begin errors++; $display("FAIL ignore_no_queue: busy/clk_oe=%b required 00", {busy, ps2_clk_oe}); end
    $display("tx ignore byte=ED bits=%b done=%0d", dev_bits, done_cnt - d0);
  endtask

  task automatic test_timeout();
`ifdef PS2_TX_TIMEOUT_EN
    int e0, d0, guard, err_cyc;
    e0 = err_cnt; d0 = done_cnt; hp = 10;
    start_tx(8'($urandom), "timeout");
    dev_run(4, 1'b0);
    guard = 0;
    while (tx_error !== 1'b1 && guard < TO + 200) begin @(negedge clk); guard++; end
    err_cyc = cyc;
    checks++;
    if (err_cyc - rel_cyc !== TO) begin errors++; $display("FAIL timeout_time: %0d cycles required %0d", err_cyc - rel_cyc, TO); end
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b000) begin
      errors++; $display("FAIL timeout_release: clk_oe/data_oe/ready=%b required 000", {ps2_clk_oe, ps2_data_oe, tx_ready});
    end
    @(negedge clk);
    checks++;
    if ({tx_ready, tx_error} !== 2'b10) begin errors++; $display("FAIL timeout_ready: ready/err=%b required 10", {tx_ready, tx_error}); end
    checks++;
    if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
      errors++; $display("FAIL timeout_count: err=%0d done=%0d required 1 0", err_cnt - e0, done_cnt - d0);
    end
    $display("tx timeout after %0d cycles", err_cyc - rel_cyc);
`endif
  endtask

  task automatic test_reset_mid();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt; hp = 10;
    start_tx(8'($urandom), "reset_mid");
    dev_run(5, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, busy, tx_ready, tx_done, tx_error} !== 6'b000100) begin
      errors++; $display("FAIL reset_mid_state: clk_oe/data_oe/busy/ready/done/err=%b required 000100",
                         {ps2_clk_oe, ps2_data_oe, busy, tx_ready, tx_done, tx_error});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
      errors++; $display("FAIL reset_mid_pulse: done=%0d err=%0d required 0 0", done_cnt - d0, err_cnt - e0);
    end
    $display("tx reset_mid aborted after 5 clocks");
    test_frame(8'hED, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [10:0] bits1;
    int d0, guard;
    d0 = done_cnt; hp = 10;
    start_tx(8'hED, "b2b_1");
    fork
      dev_run(11, 1'b0);
      begin
        guard = 0;
        while (tx_done !== 1'b1 && guard < 2000) begin @(negedge clk); guard++; end
        start_tx(8'h02, "b2b_2");
      end
    join
    bits1 = dev_bits;
    dev_run(11, 1'b0);
    checks++;
    if (bits1 !== frame_of(8'hED)) begin errors++; $display("FAIL b2b_bits1: got %b required %b", bits1, frame_of(8'hED)); end
    checks++;
    if (dev_bits !== frame_of(8'h02)) begin errors++; $display("FAIL b2b_bits2: got %b required %b", dev_bits, frame_of(8'h02)); end
    checks++;
    if (done_cnt - d0 !== 2) begin errors++; $display("FAIL b2b_done: %0d pulses required 2", done_cnt - d0); end
    $display("tx b2b bits1=%b bits2=%b done=%0d", bits1, dev_bits, done_cnt - d0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      test_frame(8'($urandom), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    test_reset();
    test_send_ed();
    test_nack();
    test_ignore_valid();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
